// File: rtl/instruction_fetch_cache.sv
// Direct-mapped, read-only instruction cache that sits between the fetch
// logic and instruction_memory. Hits return a word one cycle after the
// request. A miss stalls fetch, reads the whole 4-word line from memory,
// fills it into the cache and then returns the requested word.
module instruction_fetch_cache #(
  parameter int NUM_LINES   = 8,
  parameter int MEM_LATENCY = 2,
  parameter int COUNT_W     = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               fetch_req,
  input  logic [31:0]        pc,
  input  logic               flush,
  output logic [31:0]        instruction,
  output logic               instr_valid,
  output logic               stall,
  output logic               mem_read,
  output logic [31:0]        mem_address,
  input  logic [127:0]       mem_data_line,
  output logic [COUNT_W-1:0] miss_count
);

  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = 28 - IDX_W;
  localparam int WAIT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_LATENCY - 1);

  typedef enum logic {IDLE, MISS} state_t;

  state_t               state;
  logic [NUM_LINES-1:0] line_valid;
  logic [TAG_W-1:0]     line_tag  [NUM_LINES];
  logic [127:0]         line_data [NUM_LINES];
  logic [29:0]          miss_pc;
  logic [WAIT_W-1:0]    wait_count;
  logic                 fill_cancel;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [1:0]       req_word;
  logic             req_hit;
  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] miss_tag;
  logic [1:0]       miss_word;
  logic             fill_done;
  logic [1:0]       unused_pc_bits;

  // The byte offset within a word never affects the lookup.
  assign unused_pc_bits = pc[1:0];

  assign req_idx   = pc[3+IDX_W:4];
  assign req_tag   = pc[31:4+IDX_W];
  assign req_word  = pc[3:2];
  assign req_hit   = line_valid[req_idx] && (line_tag[req_idx] == req_tag);

  assign miss_idx  = miss_pc[1+IDX_W:2];
  assign miss_tag  = miss_pc[29:2+IDX_W];
  assign miss_word = miss_pc[1:0];
  assign fill_done = (state == MISS) && (wait_count == WAIT_LAST);

  assign stall = (state == MISS);

  function automatic logic [31:0] select_word(input logic [127:0] line,
                                              input logic [1:0]   sel);
    return line[{sel, 5'b0} +: 32];
  endfunction

  // Line payload and tag only matter once the valid bit is set, so they are not reset.
  always_ff @(posedge clock) begin
    if (fill_done) begin
      line_data[miss_idx] <= mem_data_line;
      line_tag[miss_idx]  <= miss_tag;
    end
  end

  // Lookup / miss-handling FSM with valid bits, memory strobe and miss counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      line_valid  <= '0;
      instruction <= '0;
      instr_valid <= 1'b0;
      mem_read    <= 1'b0;
      mem_address <= '0;
      wait_count  <= '0;
      miss_count  <= '0;
      miss_pc     <= '0;
      fill_cancel <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            line_valid <= '0;
          end
          if (fetch_req && req_hit && !flush) begin
            instruction <= select_word(line_data[req_idx], req_word);
            instr_valid <= 1'b1;
          end else if (fetch_req) begin
            miss_pc     <= pc[31:2];
            mem_address <= {pc[31:4], 4'b0};
            mem_read    <= 1'b1;
            wait_count  <= '0;
            miss_count  <= miss_count + 1'b1;
            fill_cancel <= 1'b0;
            instr_valid <= 1'b0;
            state       <= MISS;
          end else begin
            instr_valid <= 1'b0;
          end
        end
        MISS: begin
          instr_valid <= 1'b0;
          if (flush) begin
            line_valid  <= '0;
            fill_cancel <= 1'b1;
          end
          if (wait_count == WAIT_LAST) begin
            if (!flush && !fill_cancel) begin
              line_valid[miss_idx] <= 1'b1;
            end
            instruction <= select_word(mem_data_line, miss_word);
            instr_valid <= 1'b1;
            mem_read    <= 1'b0;
            wait_count  <= '0;
            state       <= IDLE;
          end else begin
            wait_count <= wait_count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_cache.sv
// Self-checking bench for instruction_fetch_cache: directed scenarios followed
// by randomized fetch/flush traffic, compared against a line-level cache model.
module tb_instruction_fetch_cache;

  localparam int NUM_LINES   = 8;
  localparam int MEM_LATENCY = 2;
  localparam int COUNT_W     = 4;

  logic               clock;
  logic               reset_n;
  logic               fetch_req;
  logic [31:0]        pc;
  logic               flush;
  logic [31:0]        instruction;
  logic               instr_valid;
  logic               stall;
  logic               mem_read;
  logic [31:0]        mem_address;
  logic [127:0]       mem_data_line;
  logic [COUNT_W-1:0] miss_count;

  int checks = 0;
  int errors = 0;

  // Reference model: which memory line (pc >> 4) each cache slot holds.
  bit          m_valid [NUM_LINES];
  logic [27:0] m_line  [NUM_LINES];
  int unsigned m_misses = 0;

  int rd_edges = 0;

  instruction_fetch_cache #(
    .NUM_LINES  (NUM_LINES),
    .MEM_LATENCY(MEM_LATENCY),
    .COUNT_W    (COUNT_W)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .fetch_req    (fetch_req),
    .pc           (pc),
    .flush        (flush),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .stall        (stall),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_data_line(mem_data_line),
    .miss_count   (miss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory contents: a fixed word at 0x14, a scrambled address everywhere else.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h14) return 32'h8C010004;
    return (addr * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] addr);
    logic [31:0] base;
    base = {addr[31:4], 4'b0};
    return {mem_word(base + 32'd12), mem_word(base + 32'd8),
            mem_word(base + 32'd4), mem_word(base)};
  endfunction

  // Memory only presents real data once mem_read has been high for MEM_LATENCY edges.
  always @(negedge clock) begin
    if (mem_read) rd_edges = rd_edges + 1;
    else          rd_edges = 0;
    mem_data_line = (rd_edges >= MEM_LATENCY) ? line_of(mem_address) : {4{32'hDEADBEEF}};
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int slot_of(input logic [31:0] a);
    return int'(a[31:4] % NUM_LINES);
  endfunction

  function automatic logic [63:0] exp_count();
    return 64'(m_misses % (1 << COUNT_W));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_LINES; i++) m_valid[i] = 1'b0;
    m_misses = 0;
  endtask

  // One fetch transaction, started just after a rising edge with the DUT idle.
  // flush_at selects a miss-wait cycle on which flush is raised (-1 for none);
  // mid_pc/mid_req are what the fetch side drives while the miss is pending.
  task automatic applyStimulus(input logic [31:0] a_pc, input bit a_req, input bit a_flush,
                               input int flush_at, input logic [31:0] mid_pc, input bit mid_req);
    int          slot;
    bit          is_miss;
    bit          cancel;
    logic [31:0] exp_instr;
    slot      = slot_of(a_pc);
    exp_instr = mem_word({a_pc[31:2], 2'b00});
    if (a_flush) for (int i = 0; i < NUM_LINES; i++) m_valid[i] = 1'b0;
    is_miss   = a_req && !(m_valid[slot] && m_line[slot] == a_pc[31:4]);
    pc        = a_pc;
    fetch_req = a_req;
    flush     = a_flush;
    @(posedge clock); #1;
    if (!a_req) begin
      checkOutput("idle_valid", instr_valid, 0);
      checkOutput("idle_stall", stall, 0);
    end else if (!is_miss) begin
      checkOutput("hit_valid", instr_valid, 1);
      checkOutput("hit_instr", instruction, exp_instr);
      checkOutput("hit_stall", stall, 0);
      checkOutput("hit_mem_read", mem_read, 0);
    end else begin
      m_misses++;
      checkOutput("miss_mem_read", mem_read, 1);
      checkOutput("miss_address", mem_address, {a_pc[31:4], 4'b0});
      checkOutput("miss_stall", stall, 1);
      checkOutput("miss_valid_low", instr_valid, 0);
      cancel = 1'b0;
      for (int k = 0; k < MEM_LATENCY; k++) begin
        pc        = mid_pc;
        fetch_req = mid_req;
        flush     = (k == flush_at);
        if (k == flush_at) begin
          cancel = 1'b1;
          for (int i = 0; i < NUM_LINES; i++) m_valid[i] = 1'b0;
        end
        @(posedge clock); #1;
        if (k < MEM_LATENCY - 1) begin
          checkOutput("wait_stall", stall, 1);
          checkOutput("wait_valid", instr_valid, 0);
          checkOutput("wait_mem_read", mem_read, 1);
        end
      end
      checkOutput("fill_valid", instr_valid, 1);
      checkOutput("fill_instr", instruction, exp_instr);
      checkOutput("fill_stall", stall, 0);
      checkOutput("fill_mem_read", mem_read, 0);
      if (!cancel) begin
        m_valid[slot] = 1'b1;
        m_line[slot]  = a_pc[31:4];
      end
    end
    checkOutput("miss_count", miss_count, exp_count());
    fetch_req = 1'b0;
    flush     = 1'b0;
  endtask

  // Watchdog so the run always reaches its summary.
  initial begin
    #1000000;
    errors++;
    $display("[TB] FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [31:0] rpc;
    reset_n   = 1'b0;
    fetch_req = 1'b0;
    flush     = 1'b0;
    pc        = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_valid", instr_valid, 0);
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_mem_read", mem_read, 0);
    checkOutput("rst_address", mem_address, 0);
    checkOutput("rst_instr", instruction, 0);
    checkOutput("rst_count", miss_count, 0);
    reset_n = 1'b1;

    // Cold miss, hit in the same line, conflict miss, and refetch after eviction.
    applyStimulus(32'h14, 1, 0, -1, 32'h14, 1);
    checkOutput("cold_instr_const", instruction, 32'h8C010004);
    applyStimulus(32'h18, 1, 0, -1, 32'h18, 1);
    applyStimulus(32'h94, 1, 0, -1, 32'h94, 1);
    applyStimulus(32'h14, 1, 0, -1, 32'h14, 1);
    checkOutput("conflict_count", miss_count, 3);

    // Flush while idle, flush with a request, and flush during a miss.
    applyStimulus(32'h0, 0, 1, -1, 32'h0, 0);
    applyStimulus(32'h14, 1, 0, -1, 32'h14, 1);
    applyStimulus(32'h18, 1, 1, -1, 32'h18, 1);
    applyStimulus(32'h14, 1, 0, 0, 32'h14, 1);
    applyStimulus(32'h14, 1, 0, -1, 32'h14, 1);

    // Fetch-side changes during a miss must not redirect the fill.
    applyStimulus(32'h40, 1, 0, -1, 32'h40, 1);
    applyStimulus(32'h94, 1, 0, -1, 32'h94, 1);
    applyStimulus(32'h14, 1, 0, -1, 32'h40, 1);
    applyStimulus(32'h40, 1, 0, -1, 32'h40, 1);

    // Reset arriving while the wait counter is 1.
    pc        = 32'h214;
    fetch_req = 1'b1;
    @(posedge clock); #1;
    fetch_req = 1'b0;
    checkOutput("pre_rst_mem_read", mem_read, 1);
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_mem_read", mem_read, 0);
    checkOutput("midrst_stall", stall, 0);
    checkOutput("midrst_valid", instr_valid, 0);
    checkOutput("midrst_count", miss_count, 0);
    model_reset();
    @(posedge clock); #1;
    reset_n = 1'b1;
    applyStimulus(32'h14, 1, 0, -1, 32'h14, 1);
    checkOutput("restart_count", miss_count, 1);

    // Randomized traffic over a small address window so hits, conflicts and wraps all occur.
    for (int n = 0; n < 400; n++) begin
      rpc = {22'b0, 8'($urandom_range(0, 255)), 2'($urandom)};
      if ($urandom_range(0, 9) == 0) rpc[31:28] = 4'($urandom);
      applyStimulus(rpc,
                    $urandom_range(0, 9) < 8,
                    $urandom_range(0, 99) < 8,
                    ($urandom_range(0, 99) < 15) ? $urandom_range(0, MEM_LATENCY - 1) : -1,
                    $urandom,
                    1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
